bft_leaf_port: RTL
==================

# bft_leaf_port

Leaf endpoint of the butterfly-fat-tree (BFT) deflection network: it converts client-side valid/ready streams into network packets and back. It sits below a level-0 `t_switch` port. That switch is bufferless and its arbiter always emits one slot per cycle, so this block must accept every arriving packet in the same cycle. It buffers client traffic, injects it into free outbound slots and ejects packets addressed to this leaf. Any arriving packet it cannot keep is reflected back up, which is what the deflection scheme expects of a leaf.

## Interface
Parameters:
- `PACKET_BITS`, 49: total packet width. Bit [PACKET_BITS-1] is valid, the next `ADDR_BITS` bits are the destination leaf, and the remaining low bits are payload.
- `ADDR_BITS`, 5: destination address width.
- `LEAF_ADDR`, 0: this leaf's address.
- `FIFO_DEPTH`, 8: entries per FIFO; power of two, ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `net_in`  in  PACKET_BITS  packet from the parent switch, one per cycle; valid=0 means a void slot.
- `net_out`  out  PACKET_BITS  registered packet to the parent switch.
- `tx_data`  in  PACKET_BITS-1  client packet (address + payload) to inject.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  TX FIFO not full.
- `rx_data`  out  PACKET_BITS-1  ejected packet (address + payload), taken from the RX FIFO head.
- `rx_valid`  out  1  RX FIFO not empty.
- `rx_ready`  in  1  client accepts `rx_data`.
- `reflect_cnt`  out  16  saturating count of reflected packets.

## Operation
- Classify `net_in` every cycle:
  - void;
  - "mine": valid and addr == LEAF_ADDR;
  - "foreign": valid and addr ≠ LEAF_ADDR.
- A mine packet is written to the RX FIFO when the FIFO is not full.
- A mine packet that arrives while the RX FIFO is full is reflected. Full is judged on the occupancy before any same-cycle pop.
- A foreign packet is always reflected.
- Outbound slot priority, evaluated each cycle:
  1. A reflected packet goes out as `net_out` ← `net_in`, unchanged.
  2. Otherwise, if the TX FIFO is non-empty, the head is popped and sent as `net_out` ← {1'b1, head}.
  3. Otherwise `net_out` ← all zeros (void).
- While a reflection occupies the slot, the TX head stays in place. The TX FIFO is not popped in that cycle.
- TX push occurs when `tx_valid & tx_ready`. `tx_ready` = !tx_full, derived combinationally from occupancy. The TX FIFO does not fall through.
- RX pop occurs when `rx_valid & rx_ready`. `rx_valid` = !rx_empty. `rx_data` is the current head.
- A push and a pop on the same FIFO in the same cycle are both honoured and leave occupancy unchanged. On a full TX FIFO no push occurs, because `tx_ready` = 0.
- `reflect_cnt` increments by 1 for each reflected packet and saturates at 16'hFFFF.
- Reset, asynchronous and taking effect immediately:
  - `net_out` = 0 and both FIFOs are emptied;
  - `tx_ready` = 1, `rx_valid` = 0, `reflect_cnt` = 0;
  - contents in flight at reset are discarded.

## Timing
- Reflection latency is 1 cycle: a packet sampled on `net_in` at edge k appears on `net_out` after edge k.
- Injection: a packet pushed at edge k is the TX head after edge k. It appears on `net_out` after edge k+1 at the earliest, i.e. when no reflection is pending in that cycle.
- Ejection: a mine packet sampled at edge k gives `rx_valid` = 1 after edge k when the FIFO was previously empty.
- Back-to-back operation: one inject or one reflect per cycle, and one eject per cycle. Sustained throughput is 1 packet per cycle in each direction.

## Configuration
- `BFT_LEAF_REFLECT_CNT_EN` defined: the 16-bit saturating counter is built as described above.
- `BFT_LEAF_REFLECT_CNT_EN` undefined: the counter logic is removed and `reflect_cnt` is tied to 0. All other behaviour is identical.

## Structure
- Shared package `bft_pkg`:
  - direction codes VOID=2'b00, LEFT=2'b01, RIGHT=2'b10, UP=2'b11;
  - packet layout constants: the valid bit index, plus the address field offset and width.
- Sub-module `bft_leaf_fifo`: a synchronous FIFO parameterised by width and depth, with full/empty flags and an async active-low reset. It is instantiated twice, once for TX and once for RX.

## Test plan
- Reset with traffic pending: assert `reset_n` = 0 with 3 TX entries queued. Required: `net_out` = 0, `tx_ready` = 1 and `rx_valid` = 0 immediately; no injection after release.
- Inject: with LEAF_ADDR = 0, push tx_data {addr=5, payload=0xABC} at edge 0 while `net_in` is void. Required: `net_out` = {1, 5, 0xABC} after edge 1.
- Eject: `net_in` = {1, 0, 0x123} at edge 0 with `rx_ready` = 0. Required: `rx_valid` = 1 and `rx_data` = {0, 0x123} after edge 0; the entry holds until `rx_ready` = 1.
- Foreign reflection beats injection: TX non-empty and `net_in` = {1, 7, 0x55}. Required:
  - `net_out` = {1, 7, 0x55} the next cycle;
  - the TX head is sent one cycle later;
  - `reflect_cnt` = 1.
- RX full: fill the RX FIFO with 8 entries (`rx_ready` = 0), then send `net_in` = {1, 0, 0x9}. Required: the packet is reflected to `net_out`, `reflect_cnt` increments and RX occupancy stays at 8.
- Saturation: force 65 537 reflections. Required: `reflect_cnt` = 16'hFFFF and holds.

Source files
------------

// File: rtl/bft_pkg.sv
// Shared BFT definitions: direction codes and packet layout helpers.
// Layout, MSB first: {valid, dest_addr[ADDR_BITS], payload}.
package bft_pkg;

  typedef enum logic [1:0] {
    VOID  = 2'b00,
    LEFT  = 2'b01,
    RIGHT = 2'b10,
    UP    = 2'b11
  } bft_dir_e;

  localparam int unsigned BFT_PACKET_BITS = 49;
  localparam int unsigned BFT_ADDR_BITS   = 5;

  function automatic int unsigned valid_idx(input int unsigned packet_bits);
    return packet_bits - 1;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned packet_bits,
                                           input int unsigned addr_bits);
    return packet_bits - 1 - addr_bits;
  endfunction

  localparam int unsigned BFT_VALID_IDX = valid_idx(BFT_PACKET_BITS);
  localparam int unsigned BFT_ADDR_LSB  = addr_lsb(BFT_PACKET_BITS, BFT_ADDR_BITS);
  localparam int unsigned BFT_ADDR_W    = BFT_ADDR_BITS;

endpackage

// File: rtl/bft_leaf_fifo.sv
// Synchronous FIFO with full/empty flags; head is visible on rd_data (no fall-through).
// Push while full and pop while empty are ignored.
module bft_leaf_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/bft_leaf_port.sv
// BFT leaf endpoint: injects client TX traffic, ejects packets for LEAF_ADDR,
// reflects everything else. Optional counter enabled by BFT_LEAF_REFLECT_CNT_EN.
module bft_leaf_port
  import bft_pkg::*;
#(
  parameter int unsigned PACKET_BITS = 49,
  parameter int unsigned ADDR_BITS   = 5,
  parameter int unsigned LEAF_ADDR   = 0,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [PACKET_BITS-1:0] net_in,
  output logic [PACKET_BITS-1:0] net_out,
  input  logic [PACKET_BITS-2:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [PACKET_BITS-2:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [15:0]            reflect_cnt
);

  localparam int unsigned VLD  = valid_idx(PACKET_BITS);
  localparam int unsigned ALSB = addr_lsb(PACKET_BITS, ADDR_BITS);
  localparam int unsigned DW   = PACKET_BITS - 1;

  logic                   in_valid;
  logic [ADDR_BITS-1:0]   in_addr;
  logic                   is_mine;
  logic                   rx_push;
  logic                   reflect;
  logic                   tx_full;
  logic                   tx_empty;
  logic                   tx_pop;
  logic [DW-1:0]          tx_head;
  logic                   rx_full;
  logic                   rx_empty;
  logic [PACKET_BITS-1:0] net_next;

  assign in_valid = net_in[VLD];
  assign in_addr  = net_in[ALSB +: ADDR_BITS];
  assign is_mine  = in_valid && (in_addr == ADDR_BITS'(LEAF_ADDR));

  // rx_full reflects occupancy before any same-cycle pop, so a full RX bounces.
  assign rx_push  = is_mine && !rx_full;
  assign reflect  = in_valid && !rx_push;
  assign tx_pop   = !reflect && !tx_empty;
  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;

  bft_leaf_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_valid),
    .wr_data (tx_data),
    .pop     (tx_pop),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  bft_leaf_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rx_push),
    .wr_data (net_in[DW-1:0]),
    .pop     (rx_ready),
    .rd_data (rx_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  always_comb begin
    net_next = '0;
    if (reflect)        net_next = net_in;
    else if (!tx_empty) net_next = {1'b1, tx_head};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) net_out <= '0;
    else          net_out <= net_next;
  end

`ifdef BFT_LEAF_REFLECT_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         cnt_q <= '0;
    else if (reflect && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign reflect_cnt = cnt_q;
`else
  assign reflect_cnt = '0;
`endif

endmodule
